// File: rtl/transpose_sequencer.sv
// transpose_sequencer: credit-throttled job controller producing per-stage ctrl bits and output valid/last/idx for the transpose network
module transpose_sequencer #(
  parameter int NUM_PE     = 8,
  parameter int NUM_STAGES = NUM_PE - 1,
  parameter int CREDITS    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      mode_transpose,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [NUM_STAGES-1:0]     stage_ctrl,
  output logic                      out_valid,
  output logic                      out_last,
  output logic [$clog2(NUM_PE)-1:0] out_idx,
  input  logic                      credit_return,
  output logic                      busy,
  output logic                      done,
  output logic                      credit_err
);
  localparam int W  = $clog2(NUM_PE);
  localparam int CW = $clog2(CREDITS + 1);
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
  state_t                state_q;
  logic                  mode_q;
  logic [W-1:0]          k_q;
  logic [CW-1:0]         cred_q;
  logic                  err_q;
  logic [NUM_STAGES-1:0] pv_q;
  logic [NUM_STAGES-1:0] pl_q;
  logic [W-1:0]          pi_q [NUM_STAGES];
  logic                  acc;
  logic                  last;
  logic                  full;
  assign in_ready   = (state_q == LOAD) && (cred_q != '0);
  assign acc        = in_ready && in_valid;
  assign last       = k_q == W'(NUM_PE - 1);
  assign full       = cred_q == CW'(CREDITS);
  assign out_valid  = pv_q[NUM_STAGES-1];
  assign out_last   = pl_q[NUM_STAGES-1];
  assign out_idx    = pi_q[NUM_STAGES-1];
  assign busy       = state_q != IDLE;
  assign done       = state_q == DONE;
  assign credit_err = err_q;
  // Stage 0 sees the beat in its acceptance cycle; stage s sees it s cycles
  // later, when it sits in pipeline slot s-1, so its ctrl comes from that slot.
  assign stage_ctrl[0] = acc & mode_q & (k_q != '0);
  for (genvar s = 1; s < NUM_STAGES; s++) begin : g_ctrl
    assign stage_ctrl[s] = pv_q[s-1] & mode_q & (pi_q[s-1] > W'(s));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      k_q     <= '0;
      cred_q  <= CW'(CREDITS);
      err_q   <= 1'b0;
      pv_q    <= '0;
      pl_q    <= '0;
      for (int j = 0; j < NUM_STAGES; j++) pi_q[j] <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q <= LOAD;
          mode_q  <= mode_transpose;
          k_q     <= '0;
        end
        LOAD: if (acc) begin
          k_q <= k_q + 1'b1;
          if (last) state_q <= DRAIN;
        end
        DRAIN: if (out_last) state_q <= DONE;
        DONE: state_q <= IDLE;
      endcase
      if (credit_return && full) err_q <= 1'b1;
      if (acc && !credit_return) cred_q <= cred_q - 1'b1;
      else if (credit_return && !acc && !full) cred_q <= cred_q + 1'b1;
      pv_q[0] <= acc;
      pl_q[0] <= acc & last;
      pi_q[0] <= acc ? k_q : '0;
      for (int j = 1; j < NUM_STAGES; j++) begin
        pv_q[j] <= pv_q[j-1];
        pl_q[j] <= pl_q[j-1];
        pi_q[j] <= pi_q[j-1];
      end
    end
  end
endmodule

// File: tb/tb_transpose_sequencer.sv
// tb_transpose_sequencer: directed self-checking bench for transpose_sequencer
module tb_transpose_sequencer;
  logic       clk = 1'b0;
  logic       rst, start_a, start_b, mode, in_valid, cr_auto, cr_force;
  logic       rdy_a, ov_a, ol_a, busy_a, done_a, err_a, cr_a;
  logic       rdy_b, ov_b, ol_b, busy_b, done_b, err_b, cr_b;
  logic [6:0] sc_a, sc_b;
  logic [2:0] oi_a, oi_b;
  int         checks = 0;
  int         failures = 0;
  always #5 clk = ~clk;
  assign cr_a = (cr_auto & ov_a) | cr_force;
  assign cr_b = ov_b;
  transpose_sequencer dut_a (
    .clk(clk), .rst(rst), .start(start_a), .mode_transpose(mode), .in_valid(in_valid),
    .in_ready(rdy_a), .stage_ctrl(sc_a), .out_valid(ov_a), .out_last(ol_a), .out_idx(oi_a),
    .credit_return(cr_a), .busy(busy_a), .done(done_a), .credit_err(err_a));
  transpose_sequencer #(.CREDITS(16)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .mode_transpose(mode), .in_valid(in_valid),
    .in_ready(rdy_b), .stage_ctrl(sc_b), .out_valid(ov_b), .out_last(ol_b), .out_idx(oi_b),
    .credit_return(cr_b), .busy(busy_b), .done(done_b), .credit_err(err_b));
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    if (o !== e) begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run_job(input bit use_b, input bit m, input int t[8], input logic [31:0] iv, input int sp);
    logic       acc, ov, ol, er;
    logic [2:0] oi;
    logic [6:0] ec;
    mode = m;
    in_valid = 1'b0;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    step();
    start_a = 1'b0;
    start_b = 1'b0;
    for (int c = 1; c <= t[7] + 9; c++) begin
      in_valid = iv[c];
      if (c == 2) mode = ~m;
      if (c == sp) begin
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
      end
      #1;
      acc = 1'b0; ov = 1'b0; ol = 1'b0; oi = '0; ec = '0;
      for (int k = 0; k < 8; k++) begin
        if (t[k] == c) acc = 1'b1;
        if (t[k] + 7 == c) begin ov = 1'b1; oi = 3'(k); ol = (k == 7); end
        for (int s = 0; s < 7; s++) if (t[k] + s == c && m && k > s) ec[s] = 1'b1;
      end
      er = acc || (!iv[c] && c < t[7]);
      chk("in_ready", use_b ? rdy_b : rdy_a, er);
      chk("stage_ctrl", use_b ? sc_b : sc_a, ec);
      chk("out_valid", use_b ? ov_b : ov_a, ov);
      chk("out_last", use_b ? ol_b : ol_a, ol);
      if (ov) chk("out_idx", use_b ? oi_b : oi_a, oi);
      chk("done", use_b ? done_b : done_a, logic'(c == t[7] + 8));
      chk("busy", use_b ? busy_b : busy_a, logic'(c <= t[7] + 8));
      step();
      start_a = 1'b0;
      start_b = 1'b0;
    end
    in_valid = 1'b0;
  endtask
  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; mode = 1'b0;
    in_valid = 1'b0; cr_auto = 1'b0; cr_force = 1'b0;
    step();
    step();
    chk("rst_in_ready", rdy_a, 1'b0);
    chk("rst_stage_ctrl", sc_a, 7'h00);
    chk("rst_out_valid", ov_a, 1'b0);
    chk("rst_out_last", ol_a, 1'b0);
    chk("rst_out_idx", oi_a, 3'd0);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_credit_err", err_a, 1'b0);
    rst = 1'b0;
    step();
    run_job(1'b1, 1'b1, '{1, 2, 3, 4, 5, 6, 7, 8}, 32'hFFFF_FFFF, 0);
    run_job(1'b1, 1'b0, '{1, 2, 3, 4, 5, 6, 7, 8}, 32'hFFFF_FFFF, 0);
    run_job(1'b1, 1'b1, '{1, 3, 4, 7, 8, 9, 10, 11}, ~32'h0000_0064, 4);
    cr_auto = 1'b1;
    run_job(1'b0, 1'b1, '{1, 2, 3, 4, 9, 10, 11, 12}, 32'hFFFF_FFFF, 0);
    cr_auto = 1'b0;
    step();
    cr_force = 1'b1;
    step();
    cr_force = 1'b0;
    chk("credit_err_set", err_a, 1'b1);
    step();
    step();
    step();
    chk("credit_err_sticky", err_a, 1'b1);
    mode = 1'b1;
    in_valid = 1'b1;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      cr_force = (c == 2);
      #1;
      chk("overflow_sim_ready", rdy_a, logic'(c <= 5));
      if (c == 6) rst = 1'b1;
      step();
    end
    cr_force = 1'b0;
    chk("midrst_busy", busy_a, 1'b0);
    chk("midrst_stage_ctrl", sc_a, 7'h00);
    chk("midrst_out_valid", ov_a, 1'b0);
    chk("midrst_in_ready", rdy_a, 1'b0);
    chk("midrst_credit_err", err_a, 1'b0);
    chk("midrst_done", done_a, 1'b0);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      chk("postrst_out_valid", ov_a, 1'b0);
      chk("postrst_done", done_a, 1'b0);
      step();
    end
    in_valid = 1'b0;
    cr_auto = 1'b1;
    run_job(1'b0, 1'b1, '{1, 2, 3, 4, 9, 10, 11, 12}, 32'hFFFF_FFFF, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/transpose_sequencer.md
# transpose_sequencer

Controller for the switch-stage transpose network: accepts one matrix of NUM_PE row beats per job, computes the per-stage `ctrl` bit for every beat, and delays each bit so it reaches stage s in the same cycle as the beat. It also generates output valid/last/index aligned with the fixed network latency. Because the stages have no enable, input is throttled with credits returned by the downstream consumer. The block sits between the polynomial-load front end and the stage chain, one instance per transpose network.

## Interface
- NUM_PE, 8, rows per matrix (beats per job); power of two, ≥2
- NUM_STAGES, NUM_PE-1, switch stages in the chain; network latency in cycles
- CREDITS, 4, downstream buffer slots; ≥1
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  job request pulse; honoured only in IDLE
- mode_transpose  in  1  sampled with accepted `start`: 1 = transpose, 0 = pass-through
- in_valid  in  1  upstream beat available
- in_ready  out  1  beat accepted when in_valid & in_ready
- stage_ctrl  out  NUM_STAGES  bit s drives `ctrl` of stage s
- out_valid  out  1  beat present at last stage output
- out_last  out  1  with out_valid: final beat of job
- out_idx  out  $clog2(NUM_PE)  beat index of the beat at the network output
- credit_return  in  1  one downstream slot freed
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when job's last beat leaves the network
- credit_err  out  1  sticky: credit_return while counter == CREDITS

## Operation
- FSM states are IDLE, LOAD, DRAIN and DONE.
- IDLE → LOAD on `start`. In this transition: latch mode, clear beat counter k.
- LOAD: in_ready = credits > 0. Each accepted beat increments k. On accepting beat k = NUM_PE-1, go to DRAIN.
- DRAIN: in_ready = 0. When out_last is asserted, go to DONE.
- DONE: done = 1 for one cycle, then go to IDLE.
- `start` outside IDLE is ignored.
- Schedule: beat k has ctrl bit for stage s = mode & (k > s).
- Pass-through mode: all ctrl bits 0. The beat still traverses the network and is counted.
- Ctrl pipeline: stage_ctrl[0] is combinational for the beat accepted this cycle, and is 0 if no beat is accepted.
  - A bit-vector shift register of width NUM_STAGES carries the remaining bits.
  - Bubbles propagate ctrl = 0.
- Valid pipeline: a NUM_STAGES-deep shift of {valid, last, idx}. out_* is its head.
- Credits:
  - Counter resets to CREDITS.
  - Decrement on each accepted beat; increment on credit_return.
  - Both in the same cycle: no change.
  - credit_return when the counter is full: counter unchanged, credit_err set (cleared only by rst).
- in_valid is ignored in IDLE, DRAIN and DONE.

## Timing
- Beat accepted in cycle t:
  - It is presented to stage s in cycle t+s, with stage_ctrl[s] valid in that same cycle.
  - out_valid/out_idx for it are asserted in cycle t+NUM_STAGES.
- Back-to-back acceptance: one beat per cycle while credits > 0. With credits = 0, in_ready drops in the same cycle (registered counter).
- done is asserted in the cycle after out_last. busy falls in the cycle after done.
- Minimum job length: NUM_PE + NUM_STAGES + 2 cycles, from start to busy low.
- Reset values:
  - State IDLE; in_ready 0; stage_ctrl 0; out_valid 0; out_last 0; out_idx 0; busy 0; done 0; credit_err 0.
  - Credits = CREDITS; all pipeline regs 0.
- Reset mid-job: all in-flight beats and ctrl bits are discarded in the next cycle. No done pulse and no out_valid for the discarded beats.

## Test plan
- Defaults (NUM_PE=8, NUM_STAGES=7, CREDITS=4), transpose job, in_valid held high, credit_return pulsed on every out_valid:
  - Acceptance stalls after 4 beats until the first credit returns.
  - stage_ctrl[s] is high exactly when beat k > s is at stage s.
  - out_idx is 0..7 with out_last on 7; done follows one cycle later.
- CREDITS=16, continuous beats:
  - Beats accepted at cycles 1..8; out_valid at cycles 8..15.
  - stage_ctrl[3] pattern over cycles 4..11 is 0,0,0,0,1,1,1,1.
- Pass-through job:
  - stage_ctrl stays 0 throughout.
  - Timing is identical to the transpose job; done is asserted.
- Random in_valid gaps:
  - Bubbles carry ctrl 0.
  - Each beat's ctrl bits and out_idx stay correct.
  - `start` pulses during LOAD are ignored.
- credit_return with counter at 4 → credit_err high and sticky; counter stays 4.
- Simultaneous accept and credit_return → counter unchanged.
- rst asserted while beat 5 is in LOAD:
  - Next cycle: IDLE, stage_ctrl 0, out_valid 0, credits 4.
  - No done pulse.
  - A new job then completes normally.
